// File: rtl/pc_branch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_branch_unit_if
// Bundles the control-unit side signals of the PC / branch unit.
//   start    : branch-sequence request (control unit -> unit)
//   inc_pc   : normal fetch increment request (control unit -> unit)
//   ir       : instruction register, [31:27] opcode, [18:0] displacement
//   con_q    : branch-condition result from the CON flip-flop
//   pc_out   : current program counter (unit -> control unit)
//   busy     : unit is in the middle of a branch sequence
//   done     : one-cycle pulse at the end of a branch sequence
//   taken    : branch outcome, valid with done, held until the next start
//   illegal  : one-cycle pulse with done when the opcode is not a branch
// master = control unit side, slave = pc_branch_unit side.
// ---------------------------------------------------------------------------
interface pc_branch_unit_if;
  logic        start;
  logic        inc_pc;
  logic [31:0] ir;
  logic        con_q;
  logic [31:0] pc_out;
  logic        busy;
  logic        done;
  logic        taken;
  logic        illegal;

  modport master (
    output start, inc_pc, ir, con_q,
    input  pc_out, busy, done, taken, illegal
  );

  modport slave (
    input  start, inc_pc, ir, con_q,
    output pc_out, busy, done, taken, illegal
  );
endinterface

// File: rtl/pc_branch_unit.sv
// ---------------------------------------------------------------------------
// pc_branch_unit
// Program counter with a four-state conditional-branch sequencer.
// In IDLE the PC either increments (inc_pc) or a branch sequence is started
// (start, which wins over inc_pc). The sequence computes the target in EVAL,
// samples the branch condition in TARGET and updates the PC in COMMIT.
// Ports:
//   clock   : single clock, rising edge
//   clear_n : asynchronous active-low reset
//   bus     : pc_branch_unit_if.slave (start, inc_pc, ir, con_q in;
//             pc_out, busy, done, taken, illegal out)
// Parameters:
//   RESET_PC  : PC value loaded on reset
//   BR_OPCODE : ir[31:27] value identifying a conditional branch
// ---------------------------------------------------------------------------
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [4:0]  BR_OPCODE = 5'b10010
) (
  input  logic              clock,
  input  logic              clear_n,
  pc_branch_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    TARGET,
    COMMIT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [4:0]  ir_op_q;
  logic [18:0] ir_disp_q;
  logic [31:0] target_q;
  logic        taken_q;
  logic        busy_q;
  logic        done_q;
  logic        taken_out_q;
  logic        illegal_q;

  logic [31:0] pc_inc_d;
  logic [31:0] target_d;
  logic        opcode_ok;

  // Only the opcode and displacement fields of the instruction affect the
  // sequence, so only those bits are latched.
  // Bit 18 of the displacement is its sign; 32-bit adds wrap modulo 2^32.
  always_comb begin
    pc_inc_d  = pc_q + 32'd1;
    target_d  = pc_q + {{13{ir_disp_q[18]}}, ir_disp_q};
    opcode_ok = (ir_op_q == BR_OPCODE);
  end

  // Sequencer and all architectural registers. done and illegal default low
  // every cycle so they can only ever be one-cycle pulses out of COMMIT.
  // The externally visible taken flag is held after COMMIT and only cleared
  // when the next sequence is accepted.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ir_op_q     <= '0;
      ir_disp_q   <= '0;
      target_q    <= '0;
      taken_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      taken_out_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ir_op_q     <= bus.ir[31:27];
            ir_disp_q   <= bus.ir[18:0];
            taken_out_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= EVAL;
          end else if (bus.inc_pc) begin
            pc_q <= pc_inc_d;
          end
        end
        EVAL: begin
          target_q <= target_d;
          state_q  <= TARGET;
        end
        TARGET: begin
          taken_q <= bus.con_q;
          state_q <= COMMIT;
        end
        COMMIT: begin
          if (opcode_ok) begin
            if (taken_q) begin
              pc_q <= target_q;
            end
            taken_out_q <= taken_q;
          end else begin
            taken_out_q <= 1'b0;
            illegal_q   <= 1'b1;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.pc_out  = pc_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.taken   = taken_out_q;
  assign bus.illegal = illegal_q;

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter BR_OPCODE, default 5'b10010, IR[31:27] value that identifies a conditional-branch instruction.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 clear_n  input  1  reset, asynchronous assert, active-low; polarity and synchronicity are fixed.
REQ-005 start  input  1  branch-sequence request from control unit; sampled only in IDLE.
REQ-006 inc_pc  input  1  normal fetch increment request; sampled only in IDLE.
REQ-007 ir  input  32  instruction register contents; [31:27] opcode, [18:0] signed displacement C.
REQ-008 con_q  input  1  branch-condition result from the CON flip-flop.
REQ-009 pc_out  output  32  current program counter.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  single-cycle pulse when a branch sequence completes.
REQ-012 taken  output  1  branch outcome; valid while done=1, held until the next start is accepted.
REQ-013 illegal  output  1  single-cycle pulse, coincident with done, when the latched opcode != BR_OPCODE.

Function
REQ-014 FSM states: IDLE, EVAL, TARGET, COMMIT; registered state, one transition per clock.
REQ-015 IDLE with start=1: latch ir into internal ir_q, go to EVAL; inc_pc ignored that cycle (start has priority).
REQ-016 IDLE with start=0 and inc_pc=1: pc <= pc + 1 (word addressing), stay in IDLE.
REQ-017 start and inc_pc are ignored while busy=1; there is no queuing.
REQ-018 EVAL: compute target_q <= pc + sign_extend32(ir_q[18:0]); go to TARGET.
REQ-019 TARGET: sample con_q into taken_q; go to COMMIT. con_q is ignored in every other state.
REQ-020 COMMIT, opcode match: if taken_q=1 then pc <= target_q, otherwise pc is unchanged; assert done=1 and drive taken=taken_q; go to IDLE.
REQ-021 COMMIT, opcode mismatch: pc unchanged, taken=0, done=1, illegal=1; go to IDLE.
REQ-022 Latency: start accepted at edge N gives done=1 during the cycle after edge N+3; a new start can be accepted on the following edge.
REQ-023 All PC arithmetic is modulo 2^32: 32'hFFFF_FFFF + 1 = 0; target overflow and underflow wrap silently.
REQ-024 Displacement range is -262144 to +262143 words; bit 18 is the sign bit.
REQ-025 pc_out is driven directly from the PC register, with no combinational path from inputs.
REQ-026 done and illegal are registered and high for exactly one cycle per sequence.

Reset
REQ-027 clear_n=0 asynchronously forces: pc=RESET_PC, state=IDLE, busy=0, done=0, taken=0, illegal=0, ir_q=0, target_q=0, taken_q=0.
REQ-028 Reset asserted mid-sequence aborts the sequence with no PC update; after release the block is in IDLE and responds on the first rising edge after clear_n=1.
REQ-029 Inputs are ignored while clear_n=0.

Verification
REQ-030 Reset, then 3 inc_pc cycles -> pc_out=3; pulse clear_n low mid-cycle -> pc_out=0 immediately, before any clock edge.
REQ-031 pc=0x10, ir={BR_OPCODE, 8'h00, 19'h00020}, con_q=1 in TARGET -> done after 4 edges, taken=1, pc_out=0x30.
REQ-032 Same instruction, con_q=0 -> done=1, taken=0, pc_out stays 0x10; inc_pc during busy has no effect.
REQ-033 pc=0x10, C=19'h7FFF0 (-16), taken -> pc_out=0x0; pc=0x5, C=-16 -> pc_out=0xFFFF_FFF5 (wrap).
REQ-034 Opcode 5'b00000 with start -> illegal=1 and done=1 in the same cycle, taken=0, pc unchanged.
REQ-035 start and inc_pc asserted together in IDLE -> no increment, sequence starts; clear_n asserted in TARGET -> pc=RESET_PC, no done pulse.
